// File: rtl/qsys0_copy_pkg.sv
// Shared types and constants for the qsys0 memory copy engine.
package qsys0_copy_pkg;

  // Copy engine sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  // All-ones byte enable; sliced down to DATA_W/8 at the use site (covers up to 256-bit data).
  localparam logic [31:0] BE_ALL = '1;

endpackage

// File: rtl/qsys0_mem_copy_master_if.sv
// Avalon-MM bus between the copy engine (master) and one memory slave port.
interface qsys0_mem_copy_master_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/qsys0_copy_fifo.sv
// Chunk buffer: synchronous show-ahead FIFO, head word visible on dout without a pop.
module qsys0_copy_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];

  // Storage array carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/qsys0_mem_copy_master.sv
// Avalon-MM copy engine: reads a chunk into a local buffer, writes it back, repeats.
module qsys0_mem_copy_master
  import qsys0_copy_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int BUF_DEPTH    = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            src_addr,
  input  logic [ADDR_W-1:0]            dst_addr,
  input  logic [ADDR_W:0]              len,
  output logic                         busy,
  output logic                         done,
  qsys0_mem_copy_master_if.master      avm
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam int BE_W  = DATA_W / 8;

  state_t                  state;
  logic [ADDR_W-1:0]       src_ptr;
  logic [ADDR_W-1:0]       dst_ptr;
  logic [ADDR_W-1:0]       addr_q;
  logic [LEN_W-1:0]        remaining;
  logic [CNT_W-1:0]        chunk;
  logic [CNT_W-1:0]        issue_cnt;
  logic [CNT_W-1:0]        wr_cnt;
  logic                    rd_q;
  logic                    wr_q;
  logic                    busy_q;
  logic                    done_q;
  logic [READ_LATENCY-1:0] vld_p;

  logic                    rd_acc;
  logic                    wr_acc;
  logic                    push;
  logic                    drain_ok;
  logic [DATA_W-1:0]       fifo_dout;
  logic                    fifo_empty;
  logic                    unused_fifo_full;
  logic [CNT_W-1:0]        fifo_count;

  function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_W-1:0] rem);
    if (rem >= LEN_W'(BUF_DEPTH)) return CNT_W'(BUF_DEPTH);
    return rem[CNT_W-1:0];
  endfunction

  assign rd_acc   = rd_q & ~avm.waitrequest;
  assign wr_acc   = wr_q & ~avm.waitrequest;
  assign push     = vld_p[READ_LATENCY-1];
  // Chunk fully buffered once the word arriving now (if any) completes the count.
  assign drain_ok = ((fifo_count + CNT_W'(push)) == chunk);

  assign avm.address    = addr_q;
  assign avm.read       = rd_q;
  assign avm.write      = wr_q;
  assign avm.chipselect = rd_q | wr_q;
  assign avm.byteenable = (rd_q | wr_q) ? BE_ALL[BE_W-1:0] : '0;
  assign avm.writedata  = fifo_empty ? '0 : fifo_dout;
  assign busy           = busy_q;
  assign done           = done_q;

  qsys0_copy_fifo #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (avm.readdata),
    .pop     (wr_acc),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (unused_fifo_full),
    .count   (fifo_count)
  );

  // Read-return tracker: an accepted read emerges READ_LATENCY cycles later as a push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p <= '0;
    else          vld_p <= (vld_p << 1) | READ_LATENCY'(rd_acc);
  end

  // Copy sequencer with registered bus and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      addr_q    <= '0;
      remaining <= '0;
      chunk     <= '0;
      issue_cnt <= '0;
      wr_cnt    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= len;
            issue_cnt <= '0;
            wr_cnt    <= '0;
            if (len == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state  <= ST_READ;
              busy_q <= 1'b1;
              chunk  <= chunk_of(len);
              rd_q   <= 1'b1;
              addr_q <= src_addr;
            end
          end
        end
        ST_READ: begin
          if (rd_acc) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            if ((issue_cnt + CNT_W'(1)) == chunk) begin
              rd_q  <= 1'b0;
              state <= ST_DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_ok) begin
            state  <= ST_WRITE;
            wr_q   <= 1'b1;
            addr_q <= dst_ptr;
          end
        end
        ST_WRITE: begin
          if (wr_acc) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            if ((wr_cnt + CNT_W'(1)) == chunk) begin
              wr_q      <= 1'b0;
              issue_cnt <= '0;
              wr_cnt    <= '0;
              remaining <= remaining - LEN_W'(chunk);
              src_ptr   <= src_ptr + ADDR_W'(chunk);
              dst_ptr   <= dst_ptr + ADDR_W'(chunk);
              if (remaining == LEN_W'(chunk)) begin
                state  <= ST_DONE;
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end else begin
                state  <= ST_READ;
                rd_q   <= 1'b1;
                addr_q <= src_ptr + ADDR_W'(chunk);
                chunk  <= chunk_of(remaining - LEN_W'(chunk));
              end
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
